// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the conditioner.
// The master side drives the raw pins and receives the conditioned outputs.
// The slave side is the conditioner itself.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner.
// Each channel has a 2-FF synchronizer feeding its own debounce FSM.
// Each channel produces a debounced level, a one-cycle press pulse and a one-cycle
// release pulse. Optional auto-repeat re-fires the press pulse while the button is held.
// All channels are independent of each other.
module btn_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000,
  parameter int REPEAT_EN       = 1
) (
  input  logic              clk,
  input  logic              rst,
  btn_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } btnState_t;

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW   = $clog2(HMAX + 1);

  // Terminal counts: the transition fires on the edge that completes the full interval.
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam bit            REP_ON    = (REPEAT_EN != 0);

  logic [NUM_BTN-1:0] syncS1;
  logic [NUM_BTN-1:0] syncS2;

  // Two-stage synchronizer for the raw asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncS1 <= '0;
      syncS2 <= '0;
    end else begin
      syncS1 <= bus.btn_in;
      syncS2 <= syncS1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
    btnState_t     state;
    logic [DW-1:0] dCnt;
    logic [HW-1:0] hCnt;
    logic          repeating;
    logic          levelR;
    logic          pressR;
    logic          releaseR;

    // Per-button debounce/repeat FSM; level and pulses are registered here.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        dCnt      <= '0;
        hCnt      <= '0;
        repeating <= 1'b0;
        levelR    <= 1'b0;
        pressR    <= 1'b0;
        releaseR  <= 1'b0;
      end else begin
        pressR   <= 1'b0;
        releaseR <= 1'b0;
        case (state)
          IDLE: begin
            levelR <= 1'b0;
            if (syncS2[i]) begin
              state <= DB_PRESS;
              dCnt  <= '0;
            end
          end
          DB_PRESS: begin
            if (!syncS2[i]) begin
              state <= IDLE;
            end else if (dCnt == DB_LAST) begin
              state     <= HELD;
              pressR    <= 1'b1;
              levelR    <= 1'b1;
              hCnt      <= '0;
              repeating <= 1'b0;
            end else begin
              dCnt <= dCnt + DB_ONE;
            end
          end
          HELD: begin
            if (!syncS2[i]) begin
              state <= DB_REL;
              dCnt  <= '0;
            end else if (REP_ON) begin
              // First repeat after the hold delay, later ones at the repeat period.
              // A pulse is suppressed if the previous cycle already pulsed, so
              // degenerate 1-cycle periods still never give back-to-back pulses.
              if ((!repeating && (hCnt == HOLD_LAST)) || (repeating && (hCnt == REP_LAST))) begin
                pressR    <= !pressR;
                hCnt      <= '0;
                repeating <= 1'b1;
              end else begin
                hCnt <= hCnt + H_ONE;
              end
            end else begin
              hCnt <= '0;
            end
          end
          DB_REL: begin
            if (syncS2[i]) begin
              // Release aborted: back to held, repeat timing starts over.
              state     <= HELD;
              hCnt      <= '0;
              repeating <= 1'b0;
            end else if (dCnt == DB_LAST) begin
              state    <= IDLE;
              releaseR <= 1'b1;
              levelR   <= 1'b0;
            end else begin
              dCnt <= dCnt + DB_ONE;
            end
          end
          default: begin
            state  <= IDLE;
            levelR <= 1'b0;
          end
        endcase
      end
    end

    assign bus.btn_level[i]   = levelR;
    assign bus.btn_press[i]   = pressR;
    assign bus.btn_release[i] = releaseR;
  end

endmodule
